// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the I2S shift/gain control slice.
package shift_ctrl_pkg;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_e;

    // One ramp step of an applied shift toward its target; holds once equal.
    function automatic int step_toward(input int cur, input int tgt);
        if (cur < tgt) begin
            return cur + 1;
        end else if (cur > tgt) begin
            return cur - 1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/i2s_edge_detect.sv
// I2S framing detector in the clk domain: bclk edges, word starts
// (lrclk change seen at a bclk fall) and frame starts (left word start).
// Decodes identically to the shift datapath so both agree on word timing.
module i2s_edge_detect
    import shift_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic lrclk,
    output logic bclk_fall,
    output logic bclk_rise,
    output logic word_start,
    output logic frame_start,
    output ch_e  word_ch
);

    logic bclk_prev;
    logic lrclk_prev;

    // Track previous bclk every clk; capture lrclk only at bclk falls.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            bclk_prev  <= 1'b0;
            lrclk_prev <= 1'b0;
        end else begin
            bclk_prev <= bclk;
            if (bclk_fall) begin
                lrclk_prev <= lrclk;
            end
        end
    end

    assign bclk_fall   = bclk_prev & ~bclk;
    assign bclk_rise   = ~bclk_prev & bclk;
    assign word_start  = bclk_fall & (lrclk != lrclk_prev);
    assign frame_start = word_start & ~lrclk;
    assign word_ch     = ch_e'(lrclk);

endmodule

// File: rtl/shift_gain_ctrl.sv
// Per-channel gain (shift) scheduler for the bit-serial I2S shift datapath.
// Holds left/right target shifts, ramps the applied shift one step every
// RAMP_FRAMES frames, and presents the current word's shift on shift_o.
// Optional feature macro: I2S_GAIN_MUTE_EN adds a mute input that ramps both
// channels to MAX_SHIFT while preserving the programmed targets.
module shift_gain_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int MAX_SHIFT   = 7,
    parameter  int RAMP_FRAMES = 4,
    localparam int SW          = $clog2(MAX_SHIFT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bclk,
    input  logic          lrclk,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic          cfg_ch,
    input  logic [SW-1:0] cfg_shift,
`ifdef I2S_GAIN_MUTE_EN
    input  logic          mute,
`endif
    output logic [SW-1:0] shift_o,
    output logic          busy
);

    localparam int             FCW    = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [SW-1:0]  MAX_S  = SW'(MAX_SHIFT);
    localparam logic [FCW-1:0] LAST_F = FCW'(RAMP_FRAMES - 1);

    logic [1:0][SW-1:0] cur_q;
    logic [1:0][SW-1:0] tgt_q;
    logic [1:0][SW-1:0] eff_tgt;
    logic [1:0][SW-1:0] cur_d;
    logic [FCW-1:0]     frame_cnt;
    logic [SW-1:0]      cfg_sat;
    logic               word_start;
    logic               frame_start;
    ch_e                word_ch;
    logic               step_now;
    logic               cfg_fire;
    logic               bclk_fall_unused;
    logic               bclk_rise_unused;

    i2s_edge_detect u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .bclk_fall   (bclk_fall_unused),
        .bclk_rise   (bclk_rise_unused),
        .word_start  (word_start),
        .frame_start (frame_start),
        .word_ch     (word_ch)
    );

    // Ramp steps happen only on the last frame boundary of each ramp period;
    // config is held off in that same cycle so a write never races a step.
    assign step_now  = frame_start && (frame_cnt == LAST_F);
    assign cfg_ready = ~frame_start;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign cfg_sat   = (int'(cfg_shift) > MAX_SHIFT) ? MAX_S : cfg_shift;

    // Effective target: programmed target, or full attenuation while muted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        eff_tgt = tgt_q;
`ifdef I2S_GAIN_MUTE_EN
        if (mute) begin
            eff_tgt = {2{MAX_S}};
        end
`endif
    end

    // Next applied shift per channel: one step toward the target on a ramp step.
    always_comb begin
        cur_d = cur_q;
        if (step_now) begin
            for (int ch = 0; ch < 2; ch++) begin
                cur_d[ch] = SW'(step_toward(int'(cur_q[ch]), int'(eff_tgt[ch])));
            end
        end
    end

    assign busy = (cur_q[0] != eff_tgt[0]) | (cur_q[1] != eff_tgt[1]);

    // Frame counter paces the ramp: wraps on the stepping frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            if (frame_cnt == LAST_F) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Applied/target shift state and the per-word shift presented to the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the two-entry shift arrays are plain flops with functional reset values
        // (fade in from full attenuation), so they are reset like any other state.
        if (!rst_n) begin
            cur_q   <= {2{MAX_S}};
            tgt_q   <= '0;
            shift_o <= MAX_S;
        end else begin
            cur_q <= cur_d;
            if (cfg_fire) begin
                tgt_q[cfg_ch] <= cfg_sat;
            end
            if (word_start) begin
                shift_o <= cur_d[word_ch];
            end
        end
    end

endmodule

// File: tb/tb_shift_gain_ctrl.sv
// Directed bench for shift_gain_ctrl: MAX_SHIFT=7/RAMP_FRAMES=2 main instance
// plus a MAX_SHIFT=5 instance for target saturation. bclk = clk/8, 32 bclk/word.
module tb_shift_gain_ctrl;
    import shift_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bclk;
    logic       lrclk;
    logic       cfg_valid;
    logic       cfg_ch;
    logic [2:0] cfg_shift;
    logic       cfg_ready;
    logic [2:0] shift_o;
    logic       busy;
    logic       cfg5_valid;
    logic       cfg5_ch;
    logic [2:0] cfg5_shift;
    logic       cfg5_ready;
    logic [2:0] shift5_o;
    logic       busy5;
`ifdef I2S_GAIN_MUTE_EN
    logic       mute;
    logic       mute5;
`endif

    int   phase;
    int   bit_cnt;
    int   word_cnt;
    logic word_ch_tb;
    int   n_cmp = 0;
    int   n_err = 0;

    shift_gain_ctrl #(.MAX_SHIFT(7), .RAMP_FRAMES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_shift (cfg_shift),
`ifdef I2S_GAIN_MUTE_EN
        .mute      (mute),
`endif
        .shift_o   (shift_o),
        .busy      (busy)
    );

    shift_gain_ctrl #(.MAX_SHIFT(5), .RAMP_FRAMES(2)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .cfg_valid (cfg5_valid),
        .cfg_ready (cfg5_ready),
        .cfg_ch    (cfg5_ch),
        .cfg_shift (cfg5_shift),
`ifdef I2S_GAIN_MUTE_EN
        .mute      (mute5),
`endif
        .shift_o   (shift5_o),
        .busy      (busy5)
    );

    always #5 clk = ~clk;

    // I2S source: bclk = clk/8, lrclk changes on bclk falls, 32 bits per word.
    initial begin
        bclk       = 1'b0;
        lrclk      = 1'b0;
        phase      = 0;
        bit_cnt    = 0;
        word_cnt   = 0;
        word_ch_tb = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 8;
            if (phase == 4) begin
                bclk = 1'b1;
            end else if (phase == 0) begin
                bclk    = 1'b0;
                bit_cnt = (bit_cnt + 1) % 64;
                if (lrclk != (bit_cnt >= 32)) begin
                    lrclk      = (bit_cnt >= 32);
                    word_ch_tb = lrclk;
                    word_cnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns at negedge+1 of the next word start on channel ch.
    task automatic wait_word(input logic ch);
        int old;
        bit found;
        old   = word_cnt;
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            #1;
            if (word_cnt != old) begin
                old = word_cnt;
                if (word_ch_tb == ch) found = 1'b1;
            end
        end
        if (!found) check("word_timeout", int'(found), 1);
    endtask

    // Next word on ch, then settle past the shift_o update.
    task automatic next_word(input logic ch);
        wait_word(ch);
        repeat (2) @(negedge clk);
    endtask

    task automatic cfg_write(input bit sel5, input logic ch, input int val);
        bit done;
        done = 1'b0;
        @(negedge clk);
        #1;
        if (sel5) begin
            cfg5_valid = 1'b1; cfg5_ch = ch; cfg5_shift = 3'(val);
        end else begin
            cfg_valid = 1'b1; cfg_ch = ch; cfg_shift = 3'(val);
        end
        for (int i = 0; i < 16 && !done; i++) begin
            if (sel5 ? cfg5_ready : cfg_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        cfg_valid  = 1'b0;
        cfg5_valid = 1'b0;
        check("cfg_accept", int'(done), 1);
    endtask

    int t1[14] = '{7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0};
    int t2[6]  = '{0, 1, 1, 2, 2, 3};
    int t3[6]  = '{3, 4, 4, 5, 5, 5};
    int t4[8]  = '{4, 3, 3, 2, 2, 1, 1, 0};
    int t5a[8] = '{0, 1, 1, 2, 2, 3, 3, 4};
    int t5b[8] = '{4, 3, 3, 2, 2, 1, 1, 1};

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 1'b0;
        cfg_shift  = '0;
        cfg5_valid = 1'b0;
        cfg5_ch    = 1'b0;
        cfg5_shift = '0;
`ifdef I2S_GAIN_MUTE_EN
        mute  = 1'b0;
        mute5 = 1'b0;
`endif

        // Reset held while the I2S stream runs; release mid left word.
        repeat (100) @(negedge clk);
        check("rst_shift", shift_o, 7);
        check("rst_busy", busy, 1);
        check("rst_ready", cfg_ready, 1);
        check("rst_shift5", shift5_o, 5);
        rst_n = 1'b1;

        // Fade-in from full attenuation, one step every second frame.
        foreach (t1[i]) begin
            next_word(CH_L);
            check("t1_left", shift_o, t1[i]);
            if (i == 0) check("t1_busy_start", busy, 1);
        end
        check("t1_busy_end", busy, 0);
        check("t1_busy5_end", busy5, 0);
        next_word(CH_R);
        check("t1_right", shift_o, 0);
        check("t1_right5", shift5_o, 0);

        // Ramp left up to 3; MAX_SHIFT=5 instance gets an out-of-range right target.
        cfg_write(1'b0, CH_L, 3);
        cfg_write(1'b1, CH_R, 7);
        check("t2_busy_write", busy, 1);
        check("t3_busy5_write", busy5, 1);
        foreach (t2[i]) begin
            next_word(CH_L);
            check("t2_left", shift_o, t2[i]);
            next_word(CH_R);
            check("t2_right", shift_o, 0);
            check("t3_right5", shift5_o, t2[i]);
        end
        check("t2_busy_done", busy, 0);

        // Saturated target stops the ramp at 5.
        foreach (t3[i]) begin
            next_word(CH_R);
            check("t3_right5_sat", shift5_o, t3[i]);
        end
        check("t3_busy5_done", busy5, 0);

        // Write presented in the stepping frame-boundary cycle.
        cfg_write(1'b0, CH_L, 5);
        next_word(CH_L);
        check("t4_pre", shift_o, 3);
        wait_word(CH_L);
        cfg_valid = 1'b1;
        cfg_ch    = CH_L;
        cfg_shift = 3'd0;
        check("t4_ready_low", cfg_ready, 0);
        @(negedge clk);
        #1;
        check("t4_ready_high", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("t4_old_tgt_step", shift_o, 4);
        foreach (t4[i]) begin
            next_word(CH_L);
            check("t4_left", shift_o, t4[i]);
        end
        check("t4_busy_done", busy, 0);

        // Mid-ramp rewrite reverses direction at the next step.
        cfg_write(1'b0, CH_L, 6);
        foreach (t5a[i]) begin
            next_word(CH_L);
            check("t5_up", shift_o, t5a[i]);
        end
        cfg_write(1'b0, CH_L, 1);
        foreach (t5b[i]) begin
            next_word(CH_L);
            check("t5_down", shift_o, t5b[i]);
        end
        check("t5_busy_done", busy, 0);

`ifdef I2S_GAIN_MUTE_EN
        // Mute ramps both channels to 7 and unmute returns to the kept targets.
        cfg_write(1'b0, CH_L, 2);
        cfg_write(1'b0, CH_R, 2);
        repeat (4) next_word(CH_L);
        check("t6_settled", shift_o, 2);
        check("t6_busy_settled", busy, 0);
        mute = 1'b1;
        #1;
        check("t6_busy_mute", busy, 1);
        repeat (10) next_word(CH_L);
        check("t6_muted_left", shift_o, 7);
        check("t6_busy_muted", busy, 0);
        next_word(CH_R);
        check("t6_muted_right", shift_o, 7);
        mute = 1'b0;
        repeat (10) next_word(CH_L);
        check("t6_unmuted_left", shift_o, 2);
        check("t6_busy_unmuted", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
